// File: rtl/c_table_build.sv
// FM-index C-table builder: counts a 2-bit symbol stream, forms the exclusive prefix sums
// C[s], and serves registered lookups on NUM_CH independent channels. The host may also load C directly.
module c_table_build #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sym_valid,
    input  logic [1:0]               sym_in,
    input  logic                     sym_last,
    input  logic                     wr_en,
    input  logic [1:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_CH-1:0]        lk_ce,
    input  logic [2*NUM_CH-1:0]      lk_sym,
    output logic [DATA_W*NUM_CH-1:0] lk_data,
    output logic [NUM_CH-1:0]        lk_valid,
    output logic                     ready,
    output logic                     busy,
    output logic                     overflow,
    output logic [DATA_W-1:0]        total
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PREFIX, S_READY} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DATA_W-1:0]         r_cnt [4];
    logic [DATA_W-1:0]         r_c   [4];
    logic [DATA_W-1:0]         r_total;
    logic [DATA_W-1:0]         r_sum;
    logic [1:0]                r_idx;
    logic                      r_ovf;
    logic [DATA_W*NUM_CH-1:0]  r_lk_data;
    logic [NUM_CH-1:0]         r_lk_valid;
    logic                      w_ready;
    logic                      w_busy;
    logic                      w_host_ok;
    logic                      w_start_ok;
    logic                      w_wr_ok;
    logic                      w_cnt_en;
    logic [DATA_W:0]           w_cnt_inc;
    logic [DATA_W:0]           w_tot_inc;
    logic [DATA_W:0]           w_sum_add;

    // Saturating add; MSB of the result flags that saturation occurred.
    function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DATA_W])
            return {1'b1, {DATA_W{1'b1}}};
        return {1'b0, s[DATA_W-1:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_READY: begin
                if (start)
                    w_next = S_COUNT;
                else if (wr_en)
                    w_next = S_READY;
            end
            S_COUNT:  if (sym_valid && sym_last) w_next = S_PREFIX;
            S_PREFIX: if (r_idx == 2'd3) w_next = S_READY;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready    = (r_state == S_READY);
        w_busy     = (r_state == S_COUNT) || (r_state == S_PREFIX);
        w_host_ok  = (r_state == S_IDLE) || (r_state == S_READY);
        w_start_ok = start && w_host_ok;
        w_wr_ok    = wr_en && !start && w_host_ok;
        w_cnt_en   = (r_state == S_COUNT) && sym_valid;
    end

    assign w_cnt_inc = sat_add(r_cnt[sym_in], DATA_W'(1));
    assign w_tot_inc = sat_add(r_total, DATA_W'(1));
    assign w_sum_add = sat_add(r_sum, r_cnt[r_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
                r_c[i]   <= '0;
            end
            r_total <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start_ok) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
                r_c[i]   <= '0;
            end
            r_total <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_wr_ok) begin
            r_c[wr_addr] <= wr_data;
        end else if (w_cnt_en) begin
            r_cnt[sym_in] <= w_cnt_inc[DATA_W-1:0];
            r_total       <= w_tot_inc[DATA_W-1:0];
            r_ovf         <= r_ovf | w_cnt_inc[DATA_W] | w_tot_inc[DATA_W];
        end else if (r_state == S_PREFIX) begin
            // Exclusive prefix: C[i] takes the sum of all smaller symbols.
            r_c[r_idx] <= r_sum;
            r_sum      <= w_sum_add[DATA_W-1:0];
            r_ovf      <= r_ovf | w_sum_add[DATA_W];
            r_idx      <= r_idx + 2'd1;
        end
    end

    // Lookups read the table before any same-cycle host write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lk_data  <= '0;
            r_lk_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_lk_valid[k] <= w_ready && lk_ce[k];
                r_lk_data[DATA_W*k +: DATA_W] <= (w_ready && lk_ce[k]) ? r_c[lk_sym[2*k +: 2]] : '0;
            end
        end
    end

    assign lk_data  = r_lk_data;
    assign lk_valid = r_lk_valid;
    assign ready    = w_ready;
    assign busy     = w_busy;
    assign overflow = r_ovf;
    assign total    = r_total;

endmodule

// File: tb/tb_c_table_build.sv
// Directed bench for c_table_build: an 8-bit two-channel instance for build, lookup, host load
// and reset cases, and a 4-bit single-channel instance for saturation.
module tb_c_table_build;

    logic        clk = 1'b0;
    logic        rst;
    int          n_chk = 0;
    int          n_err = 0;

    logic        a_start, a_sym_valid, a_sym_last, a_wr_en;
    logic [1:0]  a_sym_in, a_wr_addr;
    logic [7:0]  a_wr_data;
    logic [1:0]  a_lk_ce;
    logic [3:0]  a_lk_sym;
    logic [15:0] a_lk_data;
    logic [1:0]  a_lk_valid;
    logic        a_ready, a_busy, a_overflow;
    logic [7:0]  a_total;

    logic        b_start, b_sym_valid, b_sym_last, b_wr_en;
    logic [1:0]  b_sym_in, b_wr_addr;
    logic [3:0]  b_wr_data;
    logic [0:0]  b_lk_ce;
    logic [1:0]  b_lk_sym;
    logic [3:0]  b_lk_data;
    logic [0:0]  b_lk_valid;
    logic        b_ready, b_busy, b_overflow;
    logic [3:0]  b_total;

    always #5 clk = ~clk;

    c_table_build #(.DATA_W(8), .NUM_CH(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .sym_valid(a_sym_valid), .sym_in(a_sym_in),
        .sym_last(a_sym_last), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .lk_ce(a_lk_ce), .lk_sym(a_lk_sym), .lk_data(a_lk_data), .lk_valid(a_lk_valid),
        .ready(a_ready), .busy(a_busy), .overflow(a_overflow), .total(a_total)
    );

    c_table_build #(.DATA_W(4), .NUM_CH(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .sym_valid(b_sym_valid), .sym_in(b_sym_in),
        .sym_last(b_sym_last), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .lk_ce(b_lk_ce), .lk_sym(b_lk_sym), .lk_data(b_lk_data), .lk_valid(b_lk_valid),
        .ready(b_ready), .busy(b_busy), .overflow(b_overflow), .total(b_total)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [1:0] s, input logic last);
        a_sym_valid = 1'b1;
        a_sym_in    = s;
        a_sym_last  = last;
        tick();
        a_sym_valid = 1'b0;
        a_sym_last  = 1'b0;
    endtask

    task automatic feed_b(input logic [1:0] s, input logic last);
        b_sym_valid = 1'b1;
        b_sym_in    = s;
        b_sym_last  = last;
        tick();
        b_sym_valid = 1'b0;
        b_sym_last  = 1'b0;
    endtask

    task automatic look_a(input logic [1:0] s, input logic [7:0] exp, input string tag);
        a_lk_ce  = 2'b01;
        a_lk_sym = {2'b00, s};
        tick();
        chk(tag, a_lk_data[7:0], exp);
        chk({tag, "_vld"}, a_lk_valid, 2'b01);
        a_lk_ce = 2'b00;
    endtask

    task automatic look_b(input logic [1:0] s, input logic [3:0] exp, input string tag);
        b_lk_ce  = 1'b1;
        b_lk_sym = s;
        tick();
        chk(tag, b_lk_data, exp);
        b_lk_ce = 1'b0;
    endtask

    task automatic write_a(input logic [1:0] addr, input logic [7:0] data);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [9];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        rst = 1'b1;
        {a_start, a_sym_valid, a_sym_last, a_wr_en, a_sym_in, a_wr_addr, a_wr_data} = '0;
        a_lk_ce = '0; a_lk_sym = '0;
        {b_start, b_sym_valid, b_sym_last, b_wr_en, b_sym_in, b_wr_addr, b_wr_data} = '0;
        b_lk_ce = '0; b_lk_sym = '0;
        tick();
        tick();
        chk("rst_ready", a_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ovf", a_overflow, 0);
        chk("rst_total", a_total, 0);
        chk("rst_lkvld", a_lk_valid, 0);
        chk("rst_lkdata", a_lk_data, 0);
        rst = 1'b0;
        tick();

        // Basic build A,C,G,T,T,G,C,A,A -> counts 3,2,2,2 -> C 0,3,5,7
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("build_busy", a_busy, 1);
        a_lk_ce = 2'b11;
        for (int i = 0; i < 9; i++) begin
            feed_a(seq[i], i == 8);
            if (i == 0) begin
                chk("build_lkvld", a_lk_valid, 0);
                chk("build_lkdata", a_lk_data, 0);
            end
        end
        a_lk_ce = 2'b00;
        tick(); tick(); tick();
        chk("ready_early", a_ready, 0);
        tick();
        chk("ready_5th", a_ready, 1);
        chk("ready_busy", a_busy, 0);
        chk("total9", a_total, 9);
        chk("ovf0", a_overflow, 0);
        look_a(2'd0, 8'd0, "lk_A");
        look_a(2'd1, 8'd3, "lk_C");
        look_a(2'd2, 8'd5, "lk_G");
        look_a(2'd3, 8'd7, "lk_T");

        // Concurrent lookups: ch0=T, ch1=C
        a_lk_ce  = 2'b11;
        a_lk_sym = {2'd1, 2'd3};
        tick();
        chk("dual_ch0", a_lk_data[7:0], 7);
        chk("dual_ch1", a_lk_data[15:8], 3);
        chk("dual_vld", a_lk_valid, 2'b11);
        a_lk_ce = 2'b01;
        tick();
        chk("single_vld", a_lk_valid, 2'b01);
        chk("single_ch1", a_lk_data[15:8], 0);
        a_lk_ce = 2'b00;

        // Host load from IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", a_ready, 0);
        write_a(2'd0, 8'd0);
        chk("host_ready", a_ready, 1);
        write_a(2'd1, 8'd10);
        write_a(2'd2, 8'd20);
        write_a(2'd3, 8'd30);
        chk("host_total", a_total, 0);
        a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = 8'd99;
        a_lk_ce = 2'b01; a_lk_sym = 4'b0010;
        tick();
        a_wr_en = 1'b0;
        chk("rbw_old", a_lk_data[7:0], 20);
        tick();
        chk("rbw_new", a_lk_data[7:0], 99);
        a_lk_ce = 2'b00;
        look_a(2'd3, 8'd30, "host_T");

        // Build G,C,T with host writes during COUNT -> C 0,0,1,2
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 2'd3; a_wr_data = 8'h55;
        feed_a(2'd2, 1'b0);
        feed_a(2'd1, 1'b0);
        feed_a(2'd3, 1'b1);
        a_wr_en = 1'b0;
        tick(); tick(); tick(); tick();
        chk("wrc_ready", a_ready, 1);
        look_a(2'd3, 8'd2, "wrc_T");
        look_a(2'd2, 8'd1, "wrc_G");

        // start and wr_en together in READY: start wins
        a_start = 1'b1; a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 8'h77;
        tick();
        a_start = 1'b0; a_wr_en = 1'b0;
        chk("sw_ready", a_ready, 0);
        chk("sw_busy", a_busy, 1);
        chk("sw_total", a_total, 0);

        // Reset during PREFIX
        feed_a(2'd0, 1'b1);
        tick();
        chk("pre_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_ready", a_ready, 0);
        chk("arst_total", a_total, 0);
        chk("arst_lk", a_lk_valid, 0);
        rst = 1'b0;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        feed_a(2'd0, 1'b0);
        feed_a(2'd0, 1'b1);
        tick(); tick(); tick(); tick();
        chk("aa_total", a_total, 2);
        look_a(2'd0, 8'd0, "aa_A");
        look_a(2'd1, 8'd2, "aa_C");
        look_a(2'd2, 8'd2, "aa_G");
        look_a(2'd3, 8'd2, "aa_T");

        // Saturation at DATA_W=4: 16 A then C -> cnt A=15, C 0,15,15,15
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) feed_b(2'd0, 1'b0);
        chk("sat_ovf_cnt", b_overflow, 1);
        feed_b(2'd1, 1'b1);
        tick(); tick(); tick(); tick();
        chk("sat_ready", b_ready, 1);
        chk("sat_ovf", b_overflow, 1);
        chk("sat_total", b_total, 15);
        look_b(2'd0, 4'd0, "sat_A");
        look_b(2'd1, 4'd15, "sat_C");
        look_b(2'd2, 4'd15, "sat_G");
        look_b(2'd3, 4'd15, "sat_T");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
